// File: rtl/fetch_unit.sv
// Instruction-fetch stage: issues one req/gnt/rvalid transaction per PC and
// presents the returned word to decode, stepping the PC only on consumption.
module fetch_unit #(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        pc_advance,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        flush,
  output logic        fetch_err,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_VALID = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

  state_t      state_q;
  logic        drop_q;
  logic [7:0]  wait_cnt_q;
  logic [31:0] inst_q;
  logic [31:0] inst_pc_q;
  logic        inst_valid_q;
  logic        fetch_err_q;
  logic        pc_aligned;

  assign pc_aligned = (pc[1:0] == 2'b00);
  assign pc_plus4   = pc + 32'd4;
  assign imem_addr  = pc;
  assign imem_req   = (state_q == S_REQ) && pc_aligned;

  // Decode handshake: a transfer happens in a cycle where inst_valid and
  // inst_ready are both high; inst/inst_pc hold steady until then. A flush
  // in that cycle cancels the transfer, so the PC must not advance.
  assign pc_advance = (state_q == S_VALID) && inst_ready && !flush;

  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_valid = inst_valid_q;
  assign fetch_err  = fetch_err_q;
  assign dbg_state  = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      drop_q       <= 1'b0;
      wait_cnt_q   <= 8'd0;
      inst_q       <= 32'd0;
      inst_pc_q    <= 32'd0;
      inst_valid_q <= 1'b0;
      fetch_err_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: state_q <= S_REQ;
        S_REQ: begin
          if (!pc_aligned) begin
            state_q     <= S_ERR;
            fetch_err_q <= 1'b1;
          end else if (imem_gnt) begin
            state_q    <= S_WAIT;
            wait_cnt_q <= 8'd0;
            drop_q     <= flush;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (drop_q || flush) begin
              state_q <= S_REQ;
            end else begin
              state_q      <= S_VALID;
              inst_q       <= imem_rdata;
              inst_pc_q    <= pc;
              inst_valid_q <= 1'b1;
            end
          end else if (wait_cnt_q == WAIT_LIMIT) begin
            // A dropped fetch still occupies the bus, so it can time out too.
            state_q     <= S_ERR;
            fetch_err_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
            if (flush) drop_q <= 1'b1;
          end
        end
        S_VALID: begin
          if (flush || inst_ready) begin
            state_q      <= S_REQ;
            inst_valid_q <= 1'b0;
          end
        end
        S_ERR: state_q <= S_ERR;
        default: begin
          state_q     <= S_ERR;
          fetch_err_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by randomized traffic,
// checked against a transaction-level model of fetch, drop and handshake.
module tb_fetch_unit;

  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc = 32'd0;
  logic [31:0] pc_plus4;
  logic        pc_advance;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        flush = 1'b0;
  logic        fetch_err;
  logic [2:0]  dbg_state;

  fetch_unit #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset), .pc(pc), .pc_plus4(pc_plus4),
    .pc_advance(pc_advance), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .inst_pc(inst_pc), .flush(flush), .fetch_err(fetch_err),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard / model state ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_adv = 0;
  logic [63:0] exp_q[$];          // {inst_pc, inst} of the word awaiting decode
  logic        m_idle, m_req, m_out, m_hold, m_err, m_drop;
  int          m_age;             // cycles the outstanding fetch has waited
  int          lat;               // response latency chosen at grant
  logic [31:0] out_addr;
  logic [31:0] flush_target = 32'h0000_0100;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5C3_5A3C;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset = 1'b1;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    flush = 1'b0;
    #1;
    check("rst_inst_valid", 64'(inst_valid), 64'd0);
    check("rst_fetch_err", 64'(fetch_err), 64'd0);
    check("rst_pc_advance", 64'(pc_advance), 64'd0);
    check("rst_imem_req", 64'(imem_req), 64'd0);
    check("rst_inst", 64'(inst), 64'd0);
    check("rst_inst_pc", 64'(inst_pc), 64'd0);
    m_idle = 1'b0; m_req = 1'b0; m_out = 1'b0;
    m_hold = 1'b0; m_err = 1'b0; m_drop = 1'b0;
    m_age = 0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    m_idle = 1'b1;
  endtask

  // One clock cycle: check registered state, apply inputs, check the
  // combinational outputs, then advance the model and the PC register.
  task automatic step(input logic g, input logic rv, input logic [31:0] rd,
                      input logic rdy, input logic fl);
    logic        adv_exp;
    logic [63:0] front;
    logic [31:0] p4;
    logic [31:0] pc_nx;
    @(negedge clk);
    check("inst_valid", 64'(inst_valid), 64'(m_hold));
    check("fetch_err", 64'(fetch_err), 64'(m_err));
    if (m_hold) begin
      front = exp_q[0];
      check("inst", 64'(inst), 64'(front[31:0]));
      check("inst_pc", 64'(inst_pc), 64'(front[63:32]));
    end
    imem_gnt = g; imem_rvalid = rv; imem_rdata = rd; inst_ready = rdy; flush = fl;
    #1;
    adv_exp = m_hold && rdy && !fl;
    p4 = pc + 32'd4;
    check("imem_req", 64'(imem_req), 64'(m_req && (pc[1:0] == 2'b00)));
    check("imem_addr", 64'(imem_addr), 64'(pc));
    check("pc_plus4", 64'(pc_plus4), 64'(p4));
    check("pc_advance", 64'(pc_advance), 64'(adv_exp));
    if (pc_advance) n_adv++;

    if (m_err) begin
      m_err = 1'b1;
    end else if (m_idle) begin
      m_idle = 1'b0;
      m_req = 1'b1;
    end else if (m_req) begin
      if (pc[1:0] != 2'b00) begin
        m_req = 1'b0;
        m_err = 1'b1;
      end else if (g) begin
        m_req = 1'b0; m_out = 1'b1; m_age = 0; m_drop = fl;
        out_addr = pc;
        lat = $urandom_range(0, 3);
      end
    end else if (m_out) begin
      if (rv) begin
        m_out = 1'b0;
        if (m_drop || fl) m_req = 1'b1;
        else begin
          m_hold = 1'b1;
          exp_q.push_back({out_addr, rd});
        end
      end else if (m_age == MAX_WAIT) begin
        m_out = 1'b0;
        m_err = 1'b1;
      end else begin
        m_age++;
        if (fl) m_drop = 1'b1;
      end
    end else if (m_hold) begin
      if (fl || rdy) begin
        m_hold = 1'b0;
        m_req = 1'b1;
        void'(exp_q.pop_front());
      end
    end

    pc_nx = fl ? flush_target : (adv_exp ? p4 : pc);
    @(posedge clk);
    #1 pc = pc_nx;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int adv0;
    logic g, rv, rdy, fl;
    logic [31:0] rd, tmp;

    pc = 32'hFFFF_FFFC;
    #1;
    check("plus4_wrap", 64'(pc_plus4), 64'd0);
    pc = 32'h0;

    // Basic zero-wait fetch
    do_reset();
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 32'h2008_0005, 1'b1, 1'b0);
    check("basic_valid", 64'(inst_valid), 64'd1);
    check("basic_inst", 64'(inst), 64'h2008_0005);
    check("basic_inst_pc", 64'(inst_pc), 64'h0);
    adv0 = n_adv;
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    check("basic_one_adv", 64'(n_adv - adv0), 64'd1);
    check("basic_next_addr", 64'(imem_addr), 64'h4);

    // Decode backpressure for 5 cycles
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0);
    adv0 = n_adv;
    repeat (5) step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    check("bp_no_adv", 64'(n_adv - adv0), 64'd0);
    check("bp_inst_held", 64'(inst), 64'h1234_5678);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    check("bp_one_adv", 64'(n_adv - adv0), 64'd1);

    // Flush one cycle after grant; late response is discarded
    flush_target = 32'h0000_0100;
    step(1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
    check("fw_no_valid", 64'(inst_valid), 64'd0);
    check("fw_req", 64'(imem_req), 64'd1);
    check("fw_addr", 64'(imem_addr), 64'h100);

    // Flush together with ready in VALID
    step(1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 32'hCAFE_F00D, 1'b1, 1'b0);
    flush_target = 32'h0000_0200;
    adv0 = n_adv;
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    check("fr_no_adv", 64'(n_adv - adv0), 64'd0);
    check("fr_valid_low", 64'(inst_valid), 64'd0);

    // Timeout: grant with no response
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    repeat (4) step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    check("to_not_yet", 64'(fetch_err), 64'd0);
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    check("to_err", 64'(fetch_err), 64'd1);
    repeat (3) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    check("to_req_low", 64'(imem_req), 64'd0);

    // Misaligned PC
    pc = 32'h2;
    do_reset();
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    check("mis_err", 64'(fetch_err), 64'd1);
    check("mis_req_low", 64'(imem_req), 64'd0);

    // Asynchronous reset mid-WAIT, then mid-VALID with ready high
    pc = 32'h40;
    do_reset();
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    do_reset();
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    check("ar_restart_req", 64'(imem_req), 64'd1);
    step(1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 32'h0BAD_F00D, 1'b1, 1'b0);
    check("ar_pre_adv", 64'(pc_advance), 64'd1);
    do_reset();

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      g   = m_req && ($urandom_range(0, 2) != 0);
      rv  = m_out ? (m_age >= lat) : ($urandom_range(0, 15) == 0);
      rd  = m_out ? mem_word(out_addr) : $urandom();
      rdy = ($urandom_range(0, 9) < 6);
      fl  = ($urandom_range(0, 15) == 0);
      tmp = $urandom();
      flush_target = {tmp[31:2], 2'b00};
      step(g, rv, rd, rdy, fl);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage sitting directly downstream of the program counter register. It takes the current PC, issues a request/grant/response transaction to instruction memory, and holds the returned word for decode behind a valid/ready handshake. It drives `pc_plus4` and a one-cycle `pc_advance` enable, so the PC register steps only after decode has consumed the instruction. A pipeline flush discards any in-flight fetch.

## Interface
- `MAX_WAIT`, default 255: maximum cycles in WAIT before a timeout error (1..255).
- `clk`  in  1: clock; all state changes on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `pc`  in  32: current PC, taken from the program counter output.
- `pc_plus4`  out  32: `pc + 4`, combinational, modulo 2^32.
- `pc_advance`  out  1: one-cycle enable; PC loads its next value at this edge.
- `imem_req`  out  1: fetch request.
- `imem_addr`  out  32: fetch address, equal to `pc`.
- `imem_gnt`  in  1: memory accepted the request this cycle.
- `imem_rvalid`  in  1: response word valid this cycle.
- `imem_rdata`  in  32: response word.
- `inst_valid`  out  1: `inst` and `inst_pc` hold a valid instruction.
- `inst_ready`  in  1: decode accepts the instruction.
- `inst`  out  32: registered instruction word.
- `inst_pc`  out  32: registered PC of `inst`.
- `flush`  in  1: redirect; discard the current fetch (PC is reloaded externally at the same edge).
- `fetch_err`  out  1: sticky error flag for misaligned PC or timeout.

## Operation
- States:
  - IDLE: entered on reset.
  - REQ: request phase.
  - WAIT: waiting for the memory response.
  - VALID: instruction presented to decode.
  - ERR: halted.
- Reset values: state IDLE; `inst_valid`, `pc_advance`, `fetch_err` = 0; `inst`, `inst_pc` = 0; drop flag 0; wait counter 0.
- Combinational outputs:
  - `imem_req` = (state==REQ) && `pc[1:0]`==0.
  - `imem_addr` = `pc`.
  - `pc_advance` = (state==VALID) && `inst_ready` && !`flush`.
- IDLE → REQ unconditionally on the first edge after reset deasserts.
- REQ transitions:
  - `pc[1:0]`≠0: → ERR, no request issued.
  - `imem_gnt`: → WAIT; wait counter cleared; drop flag = `flush`.
  - Otherwise: stay in REQ. `flush` without grant keeps REQ and re-presents the new `pc`.
- WAIT transitions:
  - Counter increments each cycle without `imem_rvalid`.
  - `imem_rvalid` with drop=0 and no `flush`: latch `imem_rdata` into `inst` and `pc` into `inst_pc`; → VALID.
  - `imem_rvalid` with drop=1 or `flush`: response discarded; → REQ.
  - No `imem_rvalid` and `flush`: set drop=1.
  - Counter == `MAX_WAIT` and no `imem_rvalid`: → ERR. This applies even when drop=1.
- VALID transitions:
  - `inst_valid`=1; `inst` and `inst_pc` are stable until the handshake.
  - `inst_ready` && !`flush`: → REQ; `pc_advance` pulses in the same cycle.
  - `flush`, regardless of `inst_ready`: → REQ, no `pc_advance`, instruction dropped.
  - Otherwise: hold.
- ERR: `fetch_err`=1, `imem_req`=0, `inst_valid`=0. Leaves only on reset.
- Only one request is outstanding at a time. A response while not in WAIT is ignored.
- Reset mid-transaction: all state is cleared immediately. The bench must not drive a stale `imem_rvalid` expecting capture.

## Timing
- Zero-wait memory (gnt in the REQ cycle, rvalid in the next cycle): REQ→WAIT→VALID. `inst_valid` rises 2 cycles after REQ is entered.
- With `inst_ready` held high, throughput is one instruction per 3 cycles (REQ, WAIT, VALID).
- `pc_advance` is high in exactly the VALID handshake cycle. The next REQ sees the updated `pc` one edge later.
- `inst_valid` and `fetch_err` are registered. `imem_req`, `imem_addr`, `pc_plus4` and `pc_advance` are combinational from state and inputs.
- Timeout: ERR is entered at the edge where the counter equals `MAX_WAIT`, i.e. `MAX_WAIT`+1 cycles after WAIT is entered.
- `pc`=0xFFFFFFFC gives `pc_plus4`=0x00000000 (wrap, no flag).

## Test plan
- **Basic fetch:** reset with `pc`=0x0; memory grants immediately and returns 0x20080005 one cycle later; `inst_ready`=1 → `inst`=0x20080005, `inst_pc`=0x0, `pc_advance` pulses once, next `imem_addr`=0x4.
- **Decode backpressure:** `inst_ready`=0 for 5 cycles in VALID → `inst_valid` stays 1, `inst` unchanged, `pc_advance`=0; release `inst_ready` → exactly one `pc_advance` pulse.
- **Flush in WAIT:** `flush` one cycle after grant; the response 0xDEADBEEF arrives 3 cycles later → `inst_valid` never rises, state returns to REQ, new request issued at the redirected `pc`.
- **Flush and ready together in VALID:** `flush`=1 and `inst_ready`=1 in the same cycle → `pc_advance`=0, `inst_valid`=0 on the next cycle.
- **Errors:** with `MAX_WAIT`=4, grant but no response → `fetch_err`=1 after 5 WAIT cycles and `imem_req` stays 0. Separately, `pc`=0x2 → ERR with no request ever issued.
- **Async reset:** assert `reset` mid-WAIT between clock edges → `inst_valid`, `fetch_err` and `pc_advance` go to 0 immediately; fetch restarts via IDLE→REQ after deassertion.
